// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Imported by the arbiter top and its read-return pipe.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN
  } arb_state_e;

  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int STARVE_MAX_DEF = 8;

  function automatic int starve_w(input int smax);
    return $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// Fetch return path: rvalid follows grant by RD_LAT cycles.
// rdata tracks the memory output while valid and holds otherwise.
module imem_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_gnt,
  input  logic [31:0] i_doutb,
  output logic        o_rvalid,
  output logic [31:0] o_rdata
);

  logic        r_vld;
  logic [31:0] r_hold;
  logic        w_vld;

  assign w_vld = !rst &&
    ((RD_LAT == 0) ? i_gnt : r_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_hold <= '0;
    end else begin
      r_vld <= i_gnt;
      if (w_vld)
        r_hold <= i_doutb;
    end
  end

  assign o_rvalid = w_vld;
  // A grant's data is live on doutb in its rvalid cycle
  assign o_rdata  = rst   ? '0 :
                    w_vld ? i_doutb : r_hold;

endmodule

// File: rtl/imem_port_arb.sv
// Sequences the single imem port between host loader and core fetch.
// IDLE/CLEAR/LOAD/RUN, with a starvation guard for host patches in RUN.
module imem_port_arb
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_clr,
  input  logic              host_run,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [31:0]       host_wr_data,
  input  logic [3:0]        host_wr_be,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  output logic              busy,
  output logic              mem_ena,
  output logic [3:0]        mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [31:0]       mem_dina,
  input  logic [31:0]       mem_doutb
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SW    = starve_w(STARVE_MAX);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_clr_cnt;
  logic [IDX_W-1:0] w_clr_nxt;
  logic [SW-1:0]    r_starve;
  logic [SW-1:0]    w_starve_nxt;
  logic             w_force;
  logic [ADDR_W-1:0] w_host_a;
  logic [ADDR_W-1:0] w_core_a;

  assign w_host_a = ADDR_W'(host_wr_addr[IDX_W-1:0]);
  assign w_core_a = ADDR_W'(core_addr[IDX_W-1:0]);
  assign w_force  = host_wr_valid &&
                    (r_starve == SW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clr_cnt <= '0;
      r_starve  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_nxt;
      r_starve  <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_nxt     = '0;
    w_starve_nxt  = '0;
    host_wr_ready = 1'b0;
    core_gnt      = 1'b0;
    busy          = 1'b0;
    mem_ena       = 1'b0;
    mem_wea       = '0;
    mem_addra     = '0;
    mem_dina      = '0;
    // Outputs stay quiet while rst is held, whatever the state
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (host_clr) begin
            w_state_nxt = CLEAR;
          end else if (host_wr_valid) begin
            host_wr_ready = 1'b1;
            mem_ena       = 1'b1;
            mem_wea       = host_wr_be;
            mem_addra     = w_host_a;
            mem_dina      = host_wr_data;
            w_state_nxt   = LOAD;
          end else if (host_run) begin
            w_state_nxt = RUN;
          end
        end
        CLEAR: begin
          busy      = 1'b1;
          mem_ena   = 1'b1;
          mem_wea   = BE_ALL;
          mem_addra = ADDR_W'(r_clr_cnt);
          if (r_clr_cnt == IDX_W'(DEPTH - 1))
            w_state_nxt = LOAD;
          else
            w_clr_nxt = r_clr_cnt + 1'b1;
        end
        LOAD: begin
          host_wr_ready = 1'b1;
          if (host_wr_valid) begin
            mem_ena   = 1'b1;
            mem_wea   = host_wr_be;
            mem_addra = w_host_a;
            mem_dina  = host_wr_data;
          end
          if (host_clr)
            w_state_nxt = CLEAR;
          else if (host_run)
            w_state_nxt = RUN;
        end
        RUN: begin
          priority case (1'b1)
            (core_req && !w_force): begin
              core_gnt  = 1'b1;
              mem_ena   = 1'b1;
              mem_addra = w_core_a;
            end
            host_wr_valid: begin
              host_wr_ready = 1'b1;
              mem_ena       = 1'b1;
              mem_wea       = host_wr_be;
              mem_addra     = w_host_a;
              mem_dina      = host_wr_data;
            end
            default: ;
          endcase
          if (host_wr_valid && !host_wr_ready)
            w_starve_nxt = r_starve + 1'b1;
          // In-flight read still returns via the pipe in LOAD
          if (!host_run)
            w_state_nxt = LOAD;
        end
      endcase
    end
  end

  imem_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_gnt   (core_gnt),
    .i_doutb (mem_doutb),
    .o_rvalid(core_rvalid),
    .o_rdata (core_rdata)
  );

endmodule
